// File: rtl/ext_bus_rr_arbiter_pkg.sv
// Shared types and defaults for the external bus arbiter: FSM states,
// requester channel map and the round-robin index wrap helper.
package ext_bus_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    AS_IDLE = 2'd0,
    AS_OWN  = 2'd1,
    AS_TURN = 2'd2
  } arb_state_t;

  localparam int DEF_TMO_CYCLES = 256;
  localparam int DEF_GRANT_WAIT = 4;
  localparam int DEF_MAX_URGENT = 3;

  // Requester index of each bus channel; the I-cache always sits at 0.
  typedef enum logic [2:0] {
    BC_ICACHE    = 3'd0,
    BC_WBUF      = 3'd1,
    BC_DCACHE_RD = 3'd2,
    BC_DCACHE_WR = 3'd3,
    BC_UNCACHED  = 3'd4
  } bus_channel_t;

  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s -= n;
    return s;
  endfunction

endpackage

// File: rtl/ext_bus_rr_arbiter_rr_pick.sv
// Round-robin picker: first set req bit strictly after last_id, wrapping
// modulo NREQ. Purely combinational.
module ext_bus_rr_arbiter_rr_pick
  import ext_bus_rr_arbiter_pkg::*;
#(
  parameter int NREQ = 5,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_id,
  output logic            found,
  output logic [IDW-1:0]  id
);

  logic [IDW-1:0] idx;

  // Walk the rotated order from farthest to nearest so the nearest hit is
  // the last assignment and therefore the one that sticks.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    found = 1'b0;
    id    = '0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'(rr_wrap(int'(last_id), k, NREQ));
      if (req[idx]) begin
        found = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/ext_bus_rr_arbiter.sv
// External bus arbiter: round-robin with urgent override and urgent quota,
// grant-acceptance window and bus-timeout watchdog.
module ext_bus_rr_arbiter
  import ext_bus_rr_arbiter_pkg::*;
#(
  parameter int NREQ       = 5,
  parameter int TMO_CYCLES = DEF_TMO_CYCLES,
  parameter int GRANT_WAIT = DEF_GRANT_WAIT,
  parameter int MAX_URGENT = DEF_MAX_URGENT,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] urgent,
  input  logic            cyc,
  input  logic            ack_i,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            tmo_err,
  output logic [1:0]      mstate
);

  localparam int TW = $clog2(TMO_CYCLES);
  localparam int UW = $clog2(MAX_URGENT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
  localparam logic [TW-1:0] GW_LAST  = TW'(GRANT_WAIT - 1);

  arb_state_t     state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IDW-1:0] gnt_id_nxt, last_id, last_id_nxt;
  logic           gnt_valid_nxt, tmo_nxt;
  logic [UW-1:0]  urg_cnt, urg_cnt_nxt;
  logic [TW-1:0]  timer, timer_nxt, tbase;
  logic           seen_cyc, seen_nxt;
  logic           drop;

  logic           rr_found;
  logic [IDW-1:0] rr_id, urg_id, win;
  logic           urg_any;

  ext_bus_rr_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .req     (req),
    .last_id (last_id),
    .found   (rr_found),
    .id      (rr_id)
  );

  assign urg_any = |(req & urgent);

  always_comb begin
    urg_id = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i] && urgent[i]) urg_id = IDW'(i);
  end

  assign tbase = seen_cyc ? timer : '0;

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    tmo_nxt       = 1'b0;
    last_id_nxt   = last_id;
    urg_cnt_nxt   = urg_cnt;
    timer_nxt     = timer;
    seen_nxt      = seen_cyc;
    win           = '0;
    drop          = 1'b0;

    case (state)
      AS_IDLE: begin
        // A trailing ack from the previous owner blocks arbitration.
        if (!ack_i && rr_found) begin
          if (urg_any && urg_cnt < UW'(MAX_URGENT)) begin
            // Urgent grants leave the round-robin pointer alone so the
            // forced fair grant keeps rotating across quotas.
            win         = urg_id;
            urg_cnt_nxt = urg_cnt + 1'b1;
          end else begin
            win         = rr_id;
            urg_cnt_nxt = '0;
            last_id_nxt = rr_id;
          end
          gnt_nxt       = NREQ'(1) << win;
          gnt_id_nxt    = win;
          gnt_valid_nxt = 1'b1;
          timer_nxt     = '0;
          seen_nxt      = 1'b0;
          state_nxt     = AS_OWN;
        end
      end
      AS_OWN: begin
        if (seen_cyc && !cyc) begin
          drop = 1'b1;
        end else if (cyc) begin
          seen_nxt = 1'b1;
          if (ack_i) begin
            timer_nxt = '0;
          end else if (tbase == TMO_LAST) begin
            drop    = 1'b1;
            tmo_nxt = 1'b1;
          end else begin
            timer_nxt = tbase + 1'b1;
          end
        end else if (timer >= GW_LAST) begin
          drop = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      AS_TURN: state_nxt = AS_IDLE;
      default: begin
        state_nxt     = AS_IDLE;
        gnt_nxt       = '0;
        gnt_id_nxt    = '0;
        gnt_valid_nxt = 1'b0;
      end
    endcase

    if (drop) begin
      gnt_nxt       = '0;
      gnt_id_nxt    = '0;
      gnt_valid_nxt = 1'b0;
      state_nxt     = AS_TURN;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state     <= AS_IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      tmo_err   <= 1'b0;
      last_id   <= IDW'(NREQ - 1);
      urg_cnt   <= '0;
      timer     <= '0;
      seen_cyc  <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      tmo_err   <= tmo_nxt;
      last_id   <= last_id_nxt;
      urg_cnt   <= urg_cnt_nxt;
      timer     <= timer_nxt;
      seen_cyc  <= seen_nxt;
    end
  end

  assign mstate = state;

endmodule
